pb_cnt_multi: RTL

- Parametrised successor to the per-button press counter. Handles N pushbutton channels, each with its own synchroniser, debouncer, edge detector and CNT_W-bit event counter.
- Adds global up/down direction, wrap-or-saturate arithmetic, per-channel synchronous clear and a one-cycle press strobe.
- Sits between the board button pins and the display/LED logic. cnt_out is packed so that a channel-select mux can feed the seven-segment driver.

---
 rtl/pb_cnt_multi.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pb_cnt_multi.sv
// rtl/pb_cnt_multi.sv - N-channel debounced pushbutton press counter
// Optional auto-repeat on long hold is enabled by defining PB_CNT_AUTO_REPEAT_EN.
module pb_cnt_multi #(
  parameter int N         = 4,
  parameter int CNT_W     = 4,
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20,
  parameter int RPT_DLY   = 25000000,
  parameter int RPT_PER   = 5000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       pb,
  input  logic [N-1:0]       clr,
  input  logic               dir,
  input  logic               sat,
  output logic [N-1:0]       press,
  output logic [N-1:0]       level,
  output logic [N*CNT_W-1:0] cnt_out
);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

`ifdef PB_CNT_AUTO_REPEAT_EN
  localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int RPT_W   = $clog2(RPT_MAX) + 1;
  localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(RPT_DLY - 1);
  localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(RPT_PER - 1);
`else
  localparam int unused_rpt_cfg = RPT_DLY + RPT_PER;
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic             s1;
    logic             s2;
    logic             lvl;
    logic             prs;
    logic [DB_W-1:0]  db_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             settle;
    logic             rise;
    logic             hit;

    // settle: s2 has disagreed with level for DB_CYCLES consecutive edges
    assign settle = (s2 != lvl) && (db_cnt == DB_LAST);
    assign rise   = settle && s2;

    always_ff @(posedge clk) begin
      if (!rst) begin
        s1     <= 1'b0;
        s2     <= 1'b0;
        db_cnt <= '0;
        lvl    <= 1'b0;
      end else begin
        s1 <= pb[i];
        s2 <= s1;
        if (s2 == lvl) begin
          db_cnt <= '0;
        end else if (settle) begin
          lvl    <= s2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end
    end

`ifdef PB_CNT_AUTO_REPEAT_EN
    logic             fall;
    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_run;
    logic             rpt_fire;

    // rpt_run selects the repeat period once the initial hold delay has elapsed
    assign fall     = settle && !s2;
    assign rpt_fire = lvl && !fall &&
                      (rpt_cnt == (rpt_run ? RPT_PER_LAST : RPT_DLY_LAST));

    always_ff @(posedge clk) begin
      if (!rst || !lvl || clr[i]) begin
        rpt_cnt <= '0;
        rpt_run <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt <= '0;
        rpt_run <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_W'(1);
      end
    end

    assign hit = rise || rpt_fire;
`else
    assign hit = rise;
`endif

    always_comb begin
      cnt_nxt = cnt;
      if (clr[i]) begin
        cnt_nxt = '0;
      end else if (hit) begin
        if (!dir) begin
          if (!(sat && (cnt == '1))) cnt_nxt = cnt + CNT_W'(1);
        end else begin
          if (!(sat && (cnt == '0))) cnt_nxt = cnt - CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        prs <= 1'b0;
        cnt <= '0;
      end else begin
        prs <= hit;
        cnt <= cnt_nxt;
      end
    end

    assign press[i]                   = prs;
    assign level[i]                   = lvl;
    assign cnt_out[i*CNT_W +: CNT_W] = cnt;
  end

endmodule
